ps2_kbd_rx: RTL and testbench
=============================

// Module: ps2_kbd_rx
// PURPOSE
//  Parametrised PS/2 keyboard receiver, successor to the single-register PS/2 decoder.
//  - Deserialises 11-bit PS/2 frames and checks start, odd parity and stop bits.
//  - Folds E0/F0 prefixes into make/break events tagged as extended.
//  - Queues events in a FIFO and pops them to the consumer through a valid/ready handshake.
//  - Sits between the board PS/2 pins and the CPU/display event logic in the clk domain.
// PARAMETERS
//  FIFO_DEPTH   8      event FIFO entries, power of 2, >=2
//  SYNC_STAGES  2      ps2_clk/ps2_dat synchroniser flops, >=2
//  TIMEOUT_CYC  10000  max clk cycles between PS/2 falling edges inside a frame
//  FILTER_LEN   4      glitch-filter stability length in clk cycles (PS2_GLITCH_FILTER_EN only)
// PORTS
//  clk          in   1                     system clock
//  rst_n        in   1                     asynchronous reset, active-low
//  ps2_clk      in   1                     PS/2 clock pin, asynchronous
//  ps2_dat      in   1                     PS/2 data pin, asynchronous
//  ev_valid     out  1                     FIFO non-empty
//  ev_ready     in   1                     consumer accepts ev_data this cycle
//  ev_data      out  10                    {brk, ext, code[7:0]}, head of FIFO (first-word fall-through)
//  fifo_count   out  $clog2(FIFO_DEPTH)+1  entries held
//  err_parity   out  1                     1-cycle pulse on a parity error
//  err_frame    out  1                     1-cycle pulse on a bad stop bit or an inter-edge timeout
//  err_overflow out  1                     1-cycle pulse when an event is dropped because the FIFO is full
//  busy         out  1                     frame reception in progress (FSM != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, prefix flags cleared, synchronisers reset to 1.
//  Sampling: ps2_dat is sampled on a detected falling edge of synced ps2_clk (prev=1, cur=0).
//  FSM (all transitions on a falling edge unless stated):
//   - IDLE:   dat=0 -> DATA, bit counter=0; dat=1 -> stay IDLE.
//   - DATA:   shift LSB first; after 8th bit -> PARITY.
//   - PARITY: ok when popcount(data)+dat is odd; else latch perr. -> STOP.
//   - STOP:   dat=1 and !perr -> byte done; dat=1 and perr -> err_parity pulse;
//             dat=0 -> err_frame pulse, byte discarded (takes precedence over perr). Always -> IDLE.
//   - Timeout: in any state != IDLE, TIMEOUT_CYC cycles with no falling edge -> err_frame pulse,
//     IDLE, prefix flags cleared. The counter resets on every falling edge.
//  Decoder, on byte done:
//   - 0xE0 -> ext=1, no event. 0xF0 -> brk=1, no event.
//   - Any other byte -> push {brk,ext,byte}, then clear both flags.
//   - Any error also clears both flags.
//  Latency: push occurs the cycle after the stop-bit edge is detected; ev_valid rises the cycle after the push.
//  FIFO:
//   - pop = ev_valid & ev_ready. ev_data is stable while ev_valid=1 and ev_ready=0.
//   - push while full and no pop -> event dropped, err_overflow pulse, contents unchanged.
//   - push and pop in the same cycle while full -> both occur, count unchanged.
//   - push and pop in the same cycle while empty is impossible (the push lands first).
//   - Pointers wrap modulo FIFO_DEPTH.
//  rst_n assertion mid-frame or with a non-empty FIFO discards everything immediately (async).
// CONFIGURATION
//  PS2_GLITCH_FILTER_EN defined:
//   - Synced ps2_clk drives the edge detector only after holding a new level for FILTER_LEN consecutive clk cycles.
//   - Shorter pulses are ignored.
//   - Adds FILTER_LEN cycles to edge-detection latency.
//  Not defined: synced ps2_clk feeds the edge detector directly; FILTER_LEN is unused.
// TESTING
//  1) frame 0x1C, parity 0, stop 1, ev_ready=1 -> one event 0x01C, no error pulses.
//  2) bytes E0,F0,75 -> single event 0x375 (brk=1, ext=1); next byte 0x75 -> 0x075.
//  3) byte 0x1C with parity bit 1 -> err_parity pulse, no event; next good 0x32 -> 0x032 with flags clear.
//  4) ps2_clk held after 4 data bits for TIMEOUT_CYC+1 cycles -> err_frame pulse, busy=0; next frame decodes normally.
//  5) ev_ready=0, FIFO_DEPTH+1 codes -> fifo_count=FIFO_DEPTH, one err_overflow; drain order matches send order.
//  6) [PS2_GLITCH_FILTER_EN] 2-cycle low glitch on idle ps2_clk -> busy stays 0, no event, no error.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix folding, event FIFO with valid/ready pop.
// Event reaches ev_valid two cycles after the stop-bit edge; a full FIFO drops events. Optional PS2_GLITCH_FILTER_EN.

module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic              do_push;
  logic              do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign do_pop   = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  assign do_push  = push & (~full | do_pop);
  assign drop     = push & full & ~do_pop;
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 10000,
  parameter int FILTER_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_dat,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [9:0]                    ev_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_overflow,
  output logic                          busy
);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic                   clk_lvl;
  logic                   clk_prev;
  logic                   fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  logic             clk_flt;
  logic [FLT_W-1:0] flt_cnt;

  // The filtered level follows the synced pin only after FILTER_LEN consecutive cycles at the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_flt <= 1'b1;
      flt_cnt <= '0;
    end else if (clk_s == clk_flt) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      clk_flt <= clk_s;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end

  assign clk_lvl = clk_flt;
`else
  assign clk_lvl = clk_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_prev <= 1'b1;
    else        clk_prev <= clk_lvl;
  end

  assign fall = clk_prev & ~clk_lvl;

  state_t           state, state_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [2:0]       bit_cnt, bit_nxt;
  logic             perr, perr_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic             byte_ok;
  logic             perr_ev;
  logic             ferr_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      perr    <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_nxt;
      perr    <= perr_nxt;
      tmo_cnt <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_nxt = shift;
    bit_nxt   = bit_cnt;
    perr_nxt  = perr;
    tmo_nxt   = tmo_cnt;
    byte_ok   = 1'b0;
    perr_ev   = 1'b0;
    ferr_ev   = 1'b0;
    if (state != IDLE) tmo_nxt = tmo_cnt + TMO_W'(1);
    if (fall) begin
      tmo_nxt = '0;
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_nxt = DATA;
            bit_nxt   = '0;
            perr_nxt  = 1'b0;
          end
        end
        DATA: begin
          shift_nxt = {dat_s, shift[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          perr_nxt  = ~(^{shift, dat_s});
          state_nxt = STOP;
        end
        default: begin
          state_nxt = IDLE;
          if (!dat_s)    ferr_ev = 1'b1;
          else if (perr) perr_ev = 1'b1;
          else           byte_ok = 1'b1;
        end
      endcase
    end else if (state != IDLE && tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
      state_nxt = IDLE;
      tmo_nxt   = '0;
      ferr_ev   = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  logic       done_q;
  logic       ext;
  logic       brk;
  logic       push;
  logic [9:0] push_data;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q     <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
    end else begin
      done_q     <= byte_ok;
      err_parity <= perr_ev;
      err_frame  <= ferr_ev;
    end
  end

  // shift holds the finished byte while done_q is high: the FSM is back in IDLE and cannot shift.
  assign push      = done_q && (shift != 8'hE0) && (shift != 8'hF0);
  assign push_data = {brk, ext, shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (err_parity || err_frame) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (done_q) begin
      if (shift == 8'hE0) begin
        ext <= 1'b1;
      end else if (shift == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (10)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (ev_valid & ev_ready),
    .pop_data  (ev_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  assign ev_valid = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_overflow <= 1'b0;
    else        err_overflow <= fifo_drop;
  end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Randomised scoreboard bench for ps2_kbd_rx; expected events come from a byte-level prefix model.
module tb_ps2_kbd_rx;
  localparam int DEPTH = 8;
  localparam int TMO   = 300;
  localparam int H     = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [9:0] ev_data;
  logic [3:0] fifo_count;
  logic       err_parity, err_frame, err_overflow, busy;

  ps2_kbd_rx #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (TMO),
    .FILTER_LEN  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_data      (ev_data),
    .fifo_count   (fifo_count),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .err_overflow (err_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [9:0] exp_q[$];
  bit m_ext = 0;
  bit m_brk = 0;
  int exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int got_perr = 0, got_ferr = 0, got_ovf = 0;
  int busy_seen = 0;
  int ready_mode = 1;  // 0 random, 1 held low, 2 held high

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_parity)   got_perr++;
      if (err_frame)    got_ferr++;
      if (err_overflow) got_ovf++;
      if (busy)         busy_seen++;
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got %0h expected none", ev_data);
        end else begin
          check("event", 32'(ev_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       ev_ready = 1'($urandom_range(0, 1));
      1:       ev_ready = 1'b0;
      default: ev_ready = 1'b1;
    endcase
  end

  // Byte-level keyboard model: prefixes set flags, errors and real codes clear them.
  task automatic model(input logic [7:0] b, input bit bp, input bit bs);
    if (bs || bp) begin
      if (bs) exp_ferr++;
      else    exp_perr++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (ready_mode == 1 && exp_q.size() == DEPTH) exp_ovf++;
      else exp_q.push_back({m_brk, m_ext, b});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bp, input bit bs, input int nbits);
    logic [10:0] f;
    f = {~bs, (~^b) ^ bp, b, 1'b0};
    if (nbits == 11) model(b, bp, bs);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (H) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (3 * H) @(posedge clk);
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_err_parity"}, got_perr, exp_perr);
    check({tag, "_err_frame"}, got_ferr, exp_ferr);
    check({tag, "_err_overflow"}, got_ovf, exp_ovf);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int r;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_busy", busy, 0);
    check("rst_errs", {err_parity, err_frame, err_overflow}, 0);
    check("rst_ev_data", ev_data, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    ready_mode = 2;
    send(8'h1C, 0, 0, 11);
    settle("t1_basic");

    ready_mode = 0;
    send(8'hE0, 0, 0, 11);
    send(8'hF0, 0, 0, 11);
    send(8'h75, 0, 0, 11);
    send(8'h75, 0, 0, 11);
    settle("t2_prefix");

    send(8'h1C, 1, 0, 11);
    send(8'h32, 0, 0, 11);
    settle("t3_parity");

    send(8'hE0, 0, 0, 11);
    send(8'hA5, 0, 0, 5);
    exp_ferr++;
    m_ext = 0;
    m_brk = 0;
    repeat (TMO + 20) @(posedge clk);
    @(negedge clk);
    check("t4_busy_after_timeout", busy, 0);
    send(8'h1C, 0, 0, 11);
    settle("t4_timeout");

    ready_mode = 1;
    for (int i = 0; i <= DEPTH; i++) send(8'($urandom_range(0, 8'hDF)), 0, 0, 11);
    @(negedge clk);
    check("t5_fifo_count_full", fifo_count, DEPTH);
    check("t5_head_stable", ev_data, exp_q[0]);
    ready_mode = 0;
    settle("t5_overflow");

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      b = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      send(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0, 11);
    end
    settle("random");

`ifdef PS2_GLITCH_FILTER_EN
    busy_seen = 0;
    ps2_clk = 1'b0;
    repeat (2) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(posedge clk);
    check("t6_glitch_busy", busy_seen, 0);
    settle("t6_glitch");
`endif

    ready_mode = 1;
    send(8'h11, 0, 0, 11);
    send(8'h22, 0, 0, 11);
    send(8'h33, 0, 0, 11);
    send(8'h44, 0, 0, 4);
    @(negedge clk);
    check("rst_mid_busy_before", busy, 1);
    check("rst_mid_count_before", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_valid", ev_valid, 0);
    check("rst_mid_busy", busy, 0);
    exp_q.delete();
    m_ext = 0;
    m_brk = 0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    send(8'h5A, 0, 0, 11);
    settle("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
